disk_batch_sequencer: RTL and testbench
=======================================

Name: disk_batch_sequencer

Overview:
Batch controller that drives one disk point-generator engine through a run of consecutive indices k = start_k .. start_k+count-1. It issues one engine request per index and captures each (x, y) result into an internal FIFO. Results leave on a valid/ready stream tagged with their k. It sits between a host/config register block and the disk engine, and decouples engine latency from downstream backpressure.

Parameters:
FIFO_DEPTH, 4, result FIFO entries (power of two, >=2)
PTR_W, 2, log2(FIFO_DEPTH)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
go  in  1  single-cycle batch launch; sampled only when busy=0
start_k  in  32  first index of batch, captured on go
count  in  16  number of points in batch, captured on go
base_sel0_in  in  2  angle-sequence base select, captured on go
base_sel1_in  in  2  radius-sequence base select, captured on go
abort  in  1  stop issuing; drain in-flight request and discard it
busy  out  1  batch active (go accepted, batch_done not yet pulsed)
batch_done  out  1  one-cycle pulse at end of batch or abort
eng_start  out  1  one-cycle engine start pulse
eng_k  out  32  index presented to engine, stable from eng_start to eng_done
eng_base_sel0  out  2  registered base_sel0
eng_base_sel1  out  2  registered base_sel1
eng_ready  in  1  engine idle, can accept eng_start
eng_done  in  1  one-cycle pulse; eng_result_x/y valid in the same cycle
eng_result_x  in  32  16.16 signed x
eng_result_y  in  32  16.16 signed y
out_valid  out  1  FIFO head valid
out_ready  in  1  downstream accepts head
out_x  out  32  head x
out_y  out  32  head y
out_k  out  32  head index
out_last  out  1  head is last point of a non-aborted batch

Behaviour:
- Reset: busy=0, batch_done=0, eng_start=0, eng_k=0, eng_base_sel0/1=0, out_valid=0, out_x/out_y/out_k=0, out_last=0. FIFO empty, remaining=0. FSM enters S_IDLE. Reset mid-batch discards FIFO contents and any in-flight engine result.
- FSM states: S_IDLE, S_ISSUE, S_WAIT, S_FLUSH.
- S_IDLE: on go, capture start_k into cur_k, count into remaining, and the base selects; set busy=1. If count==0, pulse batch_done next cycle, clear busy, stay in S_IDLE. Otherwise go to S_ISSUE. go while busy=1 is ignored.
- S_ISSUE: when eng_ready=1, FIFO has a free slot (occupancy<FIFO_DEPTH), and abort=0, assert eng_start for exactly one cycle with eng_k=cur_k, then go to S_WAIT. If abort=1, go to S_FLUSH; since no request is in flight, batch_done pulses next cycle. Otherwise hold.
- A slot is reserved at issue, so the FIFO can never overflow. Only one request is in flight at a time.
- S_WAIT: on eng_done, push {eng_result_x, eng_result_y, cur_k, last=(remaining==1)}, increment cur_k (mod 2^32), and decrement remaining. If remaining becomes 0, pulse batch_done, clear busy, and go to S_IDLE; else go to S_ISSUE. If abort is seen in S_WAIT, latch it and go to S_FLUSH.
- S_FLUSH: wait for eng_done of the in-flight request and discard its result without pushing. Then pulse batch_done, clear busy, and go to S_IDLE. Already-queued FIFO entries remain deliverable.
- Ordering: batch_done of an aborted batch has no out_last entry. For a normal batch, batch_done can precede delivery of the out_last entry.
- FIFO: registered outputs are taken from the head. Pop when out_valid && out_ready. Push and pop in the same cycle are legal at any occupancy, including full (pop frees the slot) and empty (no fall-through; data appears the next cycle).
- Latency: go -> first eng_start is 2 cycles minimum. eng_done -> out_valid is 1 cycle when the FIFO is empty.
- cur_k wraps 0xFFFFFFFF -> 0x00000000.
- A new go is accepted while the FIFO still holds the previous batch's entries.

Test Plan:
- go, start_k=5, count=3, out_ready=1 -> three eng_start pulses with eng_k=5,6,7; out_k=5,6,7 in order; out_last only on k=7; one batch_done; busy low afterwards.
- go, count=0 -> no eng_start; batch_done pulses exactly once, 1 cycle after go; out_valid stays 0.
- count=8, FIFO_DEPTH=4, out_ready=0 -> exactly 4 eng_start pulses and the FSM holds in S_ISSUE. Raising out_ready for 1 cycle -> exactly one further eng_start. All 8 points are eventually delivered in k order.
- start_k=0xFFFFFFFE, count=3 -> out_k=0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- count=5, abort raised while the 3rd request is in S_WAIT -> the 3rd result is discarded; only k=start..start+1 are delivered, neither with out_last; batch_done pulses once after the 3rd eng_done.
- rst_n asserted mid-batch with 2 FIFO entries -> out_valid=0, busy=0 immediately. A subsequent go with count=1 works normally.

Source files
------------

// File: rtl/disk_batch_sequencer.sv
// disk_batch_sequencer
//   Walks one disk point-generator engine through indices
//   k = start_k .. start_k+count-1, one request in flight at a time, and
//   buffers each (x, y, k, last) result in a small FIFO that drains on a
//   valid/ready stream. A FIFO slot is reserved before each request is
//   issued, so a result always has somewhere to land.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   go, start_k, count,        batch launch and its parameters (captured
//   base_sel0_in, base_sel1_in on go while idle)
//   abort                      stop issuing, discard the in-flight result
//   busy, batch_done           batch status / end-of-batch pulse
//   eng_start, eng_k,          engine request side
//   eng_base_sel0/1, eng_ready
//   eng_done, eng_result_x/y   engine completion side
//   out_valid, out_ready,      result stream (head of FIFO)
//   out_x, out_y, out_k, out_last
module disk_batch_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic [31:0] start_k,
  input  logic [15:0] count,
  input  logic [1:0]  base_sel0_in,
  input  logic [1:0]  base_sel1_in,
  input  logic        abort,
  output logic        busy,
  output logic        batch_done,
  output logic        eng_start,
  output logic [31:0] eng_k,
  output logic [1:0]  eng_base_sel0,
  output logic [1:0]  eng_base_sel1,
  input  logic        eng_ready,
  input  logic        eng_done,
  input  logic [31:0] eng_result_x,
  input  logic [31:0] eng_result_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_x,
  output logic [31:0] out_y,
  output logic [31:0] out_k,
  output logic        out_last
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FLUSH} state_t;

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  state_t      state_q, state_d;
  logic [31:0] cur_k_q, cur_k_d;
  logic [15:0] remaining_q, remaining_d;
  logic [1:0]  sel0_q, sel0_d, sel1_q, sel1_d;
  logic        busy_q, busy_d;
  logic        batch_done_q, batch_done_d;
  logic        eng_start_q, eng_start_d;
  logic [31:0] eng_k_q, eng_k_d;
  logic        inflight_q, inflight_d;

  logic [31:0] x_mem_q [FIFO_DEPTH];
  logic [31:0] y_mem_q [FIFO_DEPTH];
  logic [31:0] k_mem_q [FIFO_DEPTH];
  logic        last_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             push, pop, fifo_full;

  // The FIFO can only be full of completed results: issue happens only with
  // no request in flight, so the occupancy check here is the reservation.
  assign fifo_full = (cnt_q == DEPTH_C);
  assign pop       = out_valid_q && out_ready;

  // Batch FSM next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    cur_k_d      = cur_k_q;
    remaining_d  = remaining_q;
    sel0_d       = sel0_q;
    sel1_d       = sel1_q;
    busy_d       = busy_q;
    batch_done_d = 1'b0;
    eng_start_d  = 1'b0;
    eng_k_d      = eng_k_q;
    inflight_d   = inflight_q;
    push         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          cur_k_d     = start_k;
          remaining_d = count;
          sel0_d      = base_sel0_in;
          sel1_d      = base_sel1_in;
          if (count == 16'd0) begin
            batch_done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (abort) begin
          state_d = S_FLUSH;
        end else if (eng_ready && !fifo_full) begin
          eng_start_d = 1'b1;
          eng_k_d     = cur_k_q;
          inflight_d  = 1'b1;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (eng_done) begin
          inflight_d = 1'b0;
          if (abort) begin
            // Abort arriving with the result: treat the result as aborted.
            batch_done_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = S_IDLE;
          end else begin
            push        = 1'b1;
            cur_k_d     = cur_k_q + 32'd1;
            remaining_d = remaining_q - 16'd1;
            if (remaining_q == 16'd1) begin
              batch_done_d = 1'b1;
              busy_d       = 1'b0;
              state_d      = S_IDLE;
            end else begin
              state_d = S_ISSUE;
            end
          end
        end else if (abort) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // Reached from S_ISSUE with nothing in flight, or from S_WAIT with
        // one request whose result must be swallowed.
        if (!inflight_q || eng_done) begin
          inflight_d   = 1'b0;
          batch_done_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointer and occupancy bookkeeping; push and pop may coincide.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    out_valid_d = (cnt_d != '0);
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cur_k_q      <= '0;
      remaining_q  <= '0;
      sel0_q       <= '0;
      sel1_q       <= '0;
      busy_q       <= 1'b0;
      batch_done_q <= 1'b0;
      eng_start_q  <= 1'b0;
      eng_k_q      <= '0;
      inflight_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_k_q      <= cur_k_d;
      remaining_q  <= remaining_d;
      sel0_q       <= sel0_d;
      sel1_q       <= sel1_d;
      busy_q       <= busy_d;
      batch_done_q <= batch_done_d;
      eng_start_q  <= eng_start_d;
      eng_k_q      <= eng_k_d;
      inflight_q   <= inflight_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
    end
  end

  // Result storage; cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        x_mem_q[i]    <= '0;
        y_mem_q[i]    <= '0;
        k_mem_q[i]    <= '0;
        last_mem_q[i] <= 1'b0;
      end
    end else if (push) begin
      x_mem_q[wr_ptr_q]    <= eng_result_x;
      y_mem_q[wr_ptr_q]    <= eng_result_y;
      k_mem_q[wr_ptr_q]    <= cur_k_q;
      last_mem_q[wr_ptr_q] <= (remaining_q == 16'd1);
    end
  end

  assign busy          = busy_q;
  assign batch_done    = batch_done_q;
  assign eng_start     = eng_start_q;
  assign eng_k         = eng_k_q;
  assign eng_base_sel0 = sel0_q;
  assign eng_base_sel1 = sel1_q;
  assign out_valid     = out_valid_q;
  assign out_x         = x_mem_q[rd_ptr_q];
  assign out_y         = y_mem_q[rd_ptr_q];
  assign out_k         = k_mem_q[rd_ptr_q];
  assign out_last      = last_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_disk_batch_sequencer.sv
// tb_disk_batch_sequencer
//   Bench for disk_batch_sequencer: a behavioural engine with fixed latency,
//   a scoreboard of expected stream entries and expected engine indices,
//   and directed batches covering normal runs, empty batches, backpressure,
//   index wrap, abort and mid-batch reset.
module tb_disk_batch_sequencer;

  localparam int ENG_LAT = 3;

  typedef struct {
    logic [31:0] k;
    logic [31:0] x;
    logic [31:0] y;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go;
  logic [31:0] start_k;
  logic [15:0] count;
  logic [1:0]  base_sel0_in, base_sel1_in;
  logic        abort;
  logic        busy, batch_done, eng_start;
  logic [31:0] eng_k;
  logic [1:0]  eng_base_sel0, eng_base_sel1;
  logic        eng_ready, eng_done;
  logic [31:0] eng_result_x, eng_result_y;
  logic        out_valid, out_ready;
  logic [31:0] out_x, out_y, out_k;
  logic        out_last;

  int checks = 0;
  int failures = 0;
  int start_count = 0;
  int done_count = 0;
  int batch_done_count = 0;
  int eng_lat_left = 0;
  logic [31:0] eng_k_held;

  exp_t        exp_q [$];
  logic [31:0] issue_q [$];
  exp_t        mon_e;
  logic [31:0] mon_k;

  disk_batch_sequencer #(.FIFO_DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .start_k(start_k), .count(count),
    .base_sel0_in(base_sel0_in), .base_sel1_in(base_sel1_in), .abort(abort),
    .busy(busy), .batch_done(batch_done), .eng_start(eng_start), .eng_k(eng_k),
    .eng_base_sel0(eng_base_sel0), .eng_base_sel1(eng_base_sel1),
    .eng_ready(eng_ready), .eng_done(eng_done),
    .eng_result_x(eng_result_x), .eng_result_y(eng_result_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_k(out_k), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Engine results are an arbitrary but fixed function of k.
  function automatic logic [31:0] expX(input logic [31:0] k);
    return (k * 32'h9E37_79B9) ^ 32'h0000_1234;
  endfunction

  function automatic logic [31:0] expY(input logic [31:0] k);
    return {k[15:0], k[31:16]} + 32'd7;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Queue the expected indices and stream entries, then pulse go.
  task automatic applyStimulus(input logic [31:0] sk, input logic [15:0] cnt, input logic push_exp);
    exp_t e;
    if (push_exp) begin
      for (int i = 0; i < int'(cnt); i++) begin
        e.k    = sk + 32'(i);
        e.x    = expX(e.k);
        e.y    = expY(e.k);
        e.last = (i == int'(cnt) - 1);
        issue_q.push_back(e.k);
        exp_q.push_back(e);
      end
    end
    @(posedge clk); #1;
    go = 1'b1;
    start_k = sk;
    count = cnt;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic waitForDone(input int target, input int budget);
    int n = 0;
    while (batch_done_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("batch_done_count", batch_done_count, target);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput("drain_left", exp_q.size(), 0);
    checkOutput("drain_out_valid", out_valid, 0);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Behavioural engine: accepts eng_start when idle, answers ENG_LAT cycles later.
  initial begin
    eng_ready = 1'b1;
    eng_done = 1'b0;
    eng_result_x = '0;
    eng_result_y = '0;
    eng_k_held = '0;
    forever begin
      @(posedge clk); #1;
      eng_done = 1'b0;
      if (!rst_n) begin
        eng_ready = 1'b1;
        eng_lat_left = 0;
      end else if (eng_lat_left > 0) begin
        eng_lat_left--;
        if (eng_lat_left == 0) begin
          eng_done = 1'b1;
          eng_result_x = expX(eng_k_held);
          eng_result_y = expY(eng_k_held);
          eng_ready = 1'b1;
        end
      end else if (eng_start) begin
        eng_ready = 1'b0;
        eng_k_held = eng_k;
        eng_lat_left = ENG_LAT;
      end
    end
  end

  // Monitor: checks engine indices and stream entries against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (eng_start) begin
        start_count++;
        if (issue_q.size() == 0) begin
          checkOutput("issue_q_depth", issue_q.size(), 1);
        end else begin
          mon_k = issue_q.pop_front();
          checkOutput("eng_k", eng_k, mon_k);
        end
      end
      if (eng_done) done_count++;
      if (batch_done) batch_done_count++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("exp_q_depth", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("out_k", out_k, mon_e.k);
          checkOutput("out_x", out_x, mon_e.x);
          checkOutput("out_y", out_y, mon_e.y);
          checkOutput("out_last", out_last, mon_e.last);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base_s, base_d, base_b;
    rst_n = 1'b0;
    go = 1'b0;
    start_k = '0;
    count = '0;
    base_sel0_in = '0;
    base_sel1_in = '0;
    abort = 1'b0;
    out_ready = 1'b1;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_batch_done", batch_done, 0);
    checkOutput("rst_eng_start", eng_start, 0);
    checkOutput("rst_eng_k", eng_k, 0);
    checkOutput("rst_sel", {eng_base_sel0, eng_base_sel1}, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", {out_x, out_y}, 0);
    checkOutput("rst_out_k_last", {out_k, out_last}, 0);
    rst_n = 1'b1;
    idleCycles(2);

    // Basic three-point batch.
    $display("[TB] basic batch k=5..7");
    base_sel0_in = 2'd2;
    base_sel1_in = 2'd1;
    base_s = start_count;
    base_b = batch_done_count;
    applyStimulus(32'd5, 16'd3, 1'b1);
    #1;
    checkOutput("busy_after_go", busy, 1);
    checkOutput("base_sel", {eng_base_sel0, eng_base_sel1}, 4'b1001);
    waitForDone(base_b + 1, 100);
    checkOutput("basic_busy_low", busy, 0);
    waitDrain(50);
    checkOutput("basic_starts", start_count - base_s, 3);
    checkOutput("basic_batch_dones", batch_done_count - base_b, 1);

    // Empty batch.
    $display("[TB] empty batch");
    base_s = start_count;
    base_b = batch_done_count;
    applyStimulus(32'd50, 16'd0, 1'b1);
    @(negedge clk);
    checkOutput("empty_done_pulse", batch_done, 1);
    @(negedge clk);
    checkOutput("empty_done_single", batch_done, 0);
    idleCycles(10);
    checkOutput("empty_starts", start_count - base_s, 0);
    checkOutput("empty_batch_dones", batch_done_count - base_b, 1);
    checkOutput("empty_out_valid", out_valid, 0);

    // Backpressure: FIFO fills at four entries.
    $display("[TB] backpressure batch k=100..107");
    out_ready = 1'b0;
    base_s = start_count;
    base_b = batch_done_count;
    applyStimulus(32'd100, 16'd8, 1'b1);
    idleCycles(40);
    checkOutput("bp_starts_full", start_count - base_s, 4);
    checkOutput("bp_busy", busy, 1);
    // A go while busy must be ignored.
    @(posedge clk); #1;
    go = 1'b1;
    start_k = 32'd999;
    count = 16'd2;
    @(posedge clk); #1;
    go = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    idleCycles(20);
    checkOutput("bp_starts_one_more", start_count - base_s, 5);
    out_ready = 1'b1;
    waitForDone(base_b + 1, 200);
    waitDrain(50);
    checkOutput("bp_starts_total", start_count - base_s, 8);

    // Index wrap.
    $display("[TB] wrap batch");
    base_b = batch_done_count;
    applyStimulus(32'hFFFF_FFFE, 16'd3, 1'b1);
    waitForDone(base_b + 1, 100);
    waitDrain(50);

    // Abort while the third request is outstanding.
    $display("[TB] abort batch");
    base_s = start_count;
    base_d = done_count;
    base_b = batch_done_count;
    for (int i = 0; i < 3; i++) issue_q.push_back(32'd200 + 32'(i));
    for (int i = 0; i < 2; i++) begin
      mon_e.k = 32'd200 + 32'(i);
      mon_e.x = expX(mon_e.k);
      mon_e.y = expY(mon_e.k);
      mon_e.last = 1'b0;
      exp_q.push_back(mon_e);
    end
    applyStimulus(32'd200, 16'd5, 1'b0);
    for (int n = 0; n < 100 && start_count < base_s + 3; n++) @(negedge clk);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    waitForDone(base_b + 1, 100);
    checkOutput("abort_dones_at_batch_done", done_count - base_d, 3);
    idleCycles(10);
    checkOutput("abort_starts", start_count - base_s, 3);
    checkOutput("abort_batch_dones", batch_done_count - base_b, 1);
    waitDrain(50);

    // Reset with two entries queued.
    $display("[TB] mid-batch reset");
    out_ready = 1'b0;
    base_d = done_count;
    applyStimulus(32'd300, 16'd4, 1'b1);
    for (int n = 0; n < 100 && done_count < base_d + 2; n++) @(negedge clk);
    @(posedge clk); #2;
    checkOutput("pre_reset_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_busy", busy, 0);
    issue_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    idleCycles(2);
    base_b = batch_done_count;
    applyStimulus(32'd400, 16'd1, 1'b1);
    waitForDone(base_b + 1, 100);
    waitDrain(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
